// File: rtl/rg_pkg.sv
// Shared types and helpers for the reaction game core: FSM states, LFSR taps,
// one-hot decode and saturating score arithmetic.
package rg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] onehot(input logic [3:0] idx, input int unsigned n);
    return (32'(idx) < n) ? (16'd1 << idx) : 16'd0;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
    return (v >= max) ? max : v + 16'd1;
  endfunction

  function automatic logic [15:0] sat_dec(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

endpackage

// File: rtl/reaction_game_core_if.sv
// Board-side bundle of the reaction game: start/switch inputs toward the core,
// LED target, timer, score and status toward the display/LED drivers.
interface reaction_game_core_if #(
  parameter int unsigned N_CH    = 16,
  parameter int unsigned TIMER_W = 6,
  parameter int unsigned SCORE_W = 6
) ();
  logic               start;
  logic [N_CH-1:0]    sw;
  logic [N_CH-1:0]    led;
  logic [TIMER_W-1:0] timer_out;
  logic [SCORE_W-1:0] score_out;
  logic [SCORE_W-1:0] best_out;
  logic               busy;
  logic               done;

  modport master (
    output start, sw,
    input  led, timer_out, score_out, best_out, busy, done
  );

  modport slave (
    input  start, sw,
    output led, timer_out, score_out, best_out, busy, done
  );
endinterface

// File: rtl/rg_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the target-selection entropy source.
module rg_lfsr
  import rg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_q
);

  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/reaction_game_core.sv
// Reaction game core: tick generation, round timer, random target selection,
// hit/miss scoring and best-score tracking around a four-state FSM.
module reaction_game_core
  import rg_pkg::*;
#(
  parameter int unsigned N_CH        = 16,
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned ROUND_TICKS = 30,
  parameter int unsigned TIMER_W     = 6,
  parameter int unsigned SCORE_W     = 6,
  parameter int unsigned PENALTY     = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  reaction_game_core_if.slave  bus
);

  localparam int unsigned IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W     = $clog2(TICK_DIV + 1);
  localparam logic [15:0] SCORE_MAX = 16'((1 << SCORE_W) - 1);

  state_e             state_q, state_d;
  logic [N_CH-1:0]    sw_meta_q, sw_sync_q, sw_prev_q, sw_rise;
  logic               start_q, start_rise;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [15:0]        lfsr;
  logic [15:0]        cand_w;
  logic [IDX_W-1:0]   cand, cand_wrap, new_target;
  logic [IDX_W-1:0]   target_q, target_d;
  logic [N_CH-1:0]    target_oh;
  logic               retarget_q, retarget_d;
  logic [N_CH-1:0]    led_q, led_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d, best_q, best_d;
  logic               busy_q, busy_d, done_q, done_d;

  rg_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_q (lfsr)
  );

  assign sw_rise    = sw_sync_q & ~sw_prev_q;
  assign start_rise = bus.start & ~start_q;
  assign tick       = (state_q == RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));
  assign target_oh  = N_CH'(onehot(4'(target_q), N_CH));

  // Candidate target; bumped by one when it would repeat the current target
  always_comb begin
    cand_w     = lfsr % 16'(N_CH);
    cand       = IDX_W'(cand_w);
    cand_wrap  = IDX_W'((cand_w + 16'd1) % 16'(N_CH));
    new_target = (cand == target_q) ? cand_wrap : cand;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    target_d   = target_q;
    retarget_d = 1'b0;
    timer_d    = timer_q;
    score_d    = score_q;
    best_d     = best_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d = LOAD;
          timer_d = TIMER_W'(ROUND_TICKS);
          score_d = '0;
        end
      end
      LOAD: begin
        target_d = new_target;
        state_d  = RUN;
      end
      RUN: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (retarget_q) begin
          target_d = new_target;
        end
        // Score is resolved before the tick so a final-tick hit still counts
        if (sw_rise == target_oh) begin
          score_d    = SCORE_W'(sat_inc(16'(score_q), SCORE_MAX));
          retarget_d = 1'b1;
        end else if ((sw_rise != '0) && (PENALTY != 0)) begin
          score_d = SCORE_W'(sat_dec(16'(score_q)));
        end
        if (tick) begin
          timer_d = timer_q - TIMER_W'(1);
          if (timer_q == TIMER_W'(1)) begin
            state_d = DONE;
            best_d  = (score_d > best_q) ? score_d : best_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    led_d  = (state_d == RUN) ? N_CH'(onehot(4'(target_d), N_CH)) : '0;
    busy_d = (state_d == LOAD) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sw_prev_q  <= '0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      target_q   <= '0;
      retarget_q <= 1'b0;
      led_q      <= '0;
      timer_q    <= '0;
      score_q    <= '0;
      best_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_meta_q  <= bus.sw;
      sw_sync_q  <= sw_meta_q;
      sw_prev_q  <= sw_sync_q;
      start_q    <= bus.start;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      retarget_q <= retarget_d;
      led_q      <= led_d;
      timer_q    <= timer_d;
      score_q    <= score_d;
      best_q     <= best_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.led       = led_q;
  assign bus.timer_out = timer_q;
  assign bus.score_out = score_q;
  assign bus.best_out  = best_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_reaction_game_core.sv
// Scoreboard bench for reaction_game_core: expected output transitions are queued
// per round and popped by a monitor whenever the status/timer/score outputs change.
module tb_reaction_game_core;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned TIMER_W = 2;
  localparam int unsigned SCORE_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reaction_game_core_if #(.N_CH(N_CH), .TIMER_W(TIMER_W), .SCORE_W(SCORE_W)) bus ();
  reaction_game_core_if #(.N_CH(N_CH), .TIMER_W(TIMER_W), .SCORE_W(SCORE_W)) bus2 ();

  reaction_game_core #(
    .N_CH(N_CH), .TICK_DIV(4), .ROUND_TICKS(3), .TIMER_W(TIMER_W),
    .SCORE_W(SCORE_W), .PENALTY(1), .LFSR_SEED(16'hACE1)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  // Long-round instance so a single round can hold enough hits to saturate
  reaction_game_core #(
    .N_CH(N_CH), .TICK_DIV(32), .ROUND_TICKS(3), .TIMER_W(TIMER_W),
    .SCORE_W(SCORE_W), .PENALTY(1), .LFSR_SEED(16'hACE1)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] timer;
    logic [3:0] score;
    logic [3:0] best;
  } obs_t;

  typedef struct {
    int unsigned dt;
    obs_t        o;
  } ev_t;

  ev_t         exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned t0       = 0;
  bit          mon_en   = 1'b0;
  bit          prev_ok  = 1'b0;
  obs_t        prev;
  logic [3:0]  l;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the observed outputs must match the next expectation
  always @(negedge clk) begin
    obs_t cur;
    ev_t  e;
    if (mon_en) begin
      cur = {bus.busy, bus.done, bus.timer_out, bus.score_out, bus.best_out};
      if (!prev_ok) begin
        prev    = cur;
        prev_ok = 1'b1;
      end else if (cur !== prev) begin
        prev   = cur;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL unexpected_event dt=%0d got=%h", cyc - t0, cur);
        end else begin
          e = exp_q.pop_front();
          if ((e.o !== cur) || (e.dt != cyc - t0)) begin
            failures = failures + 1;
            $display("FAIL event got dt=%0d obs=%h required dt=%0d obs=%h",
                     cyc - t0, cur, e.dt, e.o);
          end
        end
      end
    end
  end

  task automatic ev(int dt, int b, int d, int t, int s, int bs);
    ev_t e;
    e.dt = 32'(dt);
    e.o  = {1'(b), 1'(d), 2'(t), 4'(s), 4'(bs)};
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] req);
    checks = checks + 1;
    if (got !== req) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic wait_dt(int unsigned dt);
    while (cyc - t0 < dt) @(negedge clk);
  endtask

  task automatic start_round();
    t0        = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic press(logic [3:0] mask);
    bus.sw = mask;
    @(negedge clk);
    bus.sw = '0;
  endtask

  function automatic logic [3:0] rot(logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  initial begin
    bus.start  = 1'b0;
    bus.sw     = '0;
    bus2.start = 1'b0;
    bus2.sw    = '0;

    repeat (5) @(negedge clk);
    chk("rst_led",   32'(bus.led), 0);
    chk("rst_timer", 32'(bus.timer_out), 0);
    chk("rst_score", 32'(bus.score_out), 0);
    chk("rst_best",  32'(bus.best_out), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_led",  32'(bus.led), 0);

    // Round 1: timing, single hit, LED move, start ignored while running
    ev(1, 1, 0, 3, 0, 0); ev(5, 1, 0, 3, 1, 0); ev(6, 1, 0, 2, 1, 0);
    ev(10, 1, 0, 1, 1, 0); ev(14, 0, 1, 0, 1, 1);
    start_round();
    chk("busy_after_start", 32'(bus.busy), 1);
    wait_dt(2); l = bus.led;
    chk("led_onehot", 32'($countones(bus.led)), 1);
    press(l);
    wait_dt(5); chk("led_hold", 32'(bus.led), 32'(l));
    wait_dt(6); chk("led_moved", 32'(bus.led != l), 1);
    chk("led_onehot2", 32'($countones(bus.led)), 1);
    wait_dt(7); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_dt(16); chk("done_led", 32'(bus.led), 0);

    // Round 2: miss at zero, two hits, then a miss
    ev(1, 1, 0, 3, 0, 1); ev(6, 1, 0, 2, 1, 1); ev(10, 1, 0, 1, 2, 1); ev(14, 0, 1, 0, 1, 1);
    start_round();
    wait_dt(2); l = bus.led; press(rot(l));
    l = bus.led; press(l);
    wait_dt(7); l = bus.led; press(l);
    wait_dt(11); l = bus.led; press(rot(l));
    wait_dt(16);

    // Round 3: target plus another switch counts as a miss
    ev(1, 1, 0, 3, 0, 1); ev(5, 1, 0, 3, 1, 1); ev(6, 1, 0, 2, 1, 1); ev(9, 1, 0, 2, 0, 1);
    ev(10, 1, 0, 1, 0, 1); ev(12, 1, 0, 1, 1, 1); ev(14, 0, 1, 0, 1, 1);
    start_round();
    wait_dt(2); l = bus.led; press(l);
    wait_dt(6); l = bus.led; press(l | rot(l));
    wait_dt(9); l = bus.led; press(l);
    wait_dt(16);

    // Round 4: hit landing on the final tick raises best
    ev(1, 1, 0, 3, 0, 1); ev(5, 1, 0, 3, 1, 1); ev(6, 1, 0, 2, 1, 1); ev(9, 1, 0, 2, 2, 1);
    ev(10, 1, 0, 1, 2, 1); ev(14, 0, 1, 0, 3, 3);
    start_round();
    wait_dt(2); l = bus.led; press(l);
    wait_dt(6); l = bus.led; press(l);
    wait_dt(11); l = bus.led; press(l);
    wait_dt(16);
    chk("best_after_r4", 32'(bus.best_out), 3);

    // Round 5: lower score leaves best alone
    ev(1, 1, 0, 3, 0, 3); ev(5, 1, 0, 3, 1, 3); ev(6, 1, 0, 2, 1, 3);
    ev(10, 1, 0, 1, 1, 3); ev(14, 0, 1, 0, 1, 3);
    start_round();
    wait_dt(2); l = bus.led; press(l);
    wait_dt(16);

    // Round 6: reset mid-run aborts everything
    ev(1, 1, 0, 3, 0, 3); ev(5, 0, 0, 0, 0, 0);
    start_round();
    wait_dt(4); rst = 1'b0;
    wait_dt(5);
    chk("midrst_led",   32'(bus.led), 0);
    chk("midrst_busy",  32'(bus.busy), 0);
    chk("midrst_timer", 32'(bus.timer_out), 0);
    chk("midrst_best",  32'(bus.best_out), 0);
    wait_dt(6); rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", 32'({bus.busy, bus.done}), 0);

    // Saturation on the long-round instance: 17 hits cap at 15
    t0         = cyc;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wait_dt(32'(2 + 4 * i));
      l       = bus2.led;
      bus2.sw = l;
      @(negedge clk);
      bus2.sw = '0;
      wait_dt(32'(5 + 4 * i));
      chk("sat_score", 32'(bus2.score_out), 32'((i + 1 > 15) ? 15 : i + 1));
    end
    wait_dt(100);
    chk("sat_done",  32'(bus2.done), 1);
    chk("sat_best",  32'(bus2.best_out), 15);
    chk("sat_timer", 32'(bus2.timer_out), 0);

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reaction_game_core.md
Name: reaction_game_core

Overview:
- Parametrised successor to the current clock/timer/score top-level of the reflex-reaction game.
- Folds tick generation, round timer, target selection, hit/miss scoring and best-score tracking into one FSM-driven block.
- Channel count, round length, tick rate and penalty mode are parametrised.
- Sits between the board I/O (debounced start button, slide switches, LEDs) and the 7-segment display driver.

Parameters:
N_CH, 16, number of LED/switch channels (2..16)
TICK_DIV, 100000000, clk cycles per timer tick (1 Hz at 100 MHz)
ROUND_TICKS, 30, round length in ticks
TIMER_W, 6, timer output width; must hold ROUND_TICKS
SCORE_W, 6, score/best width
PENALTY, 1, 1 = wrong switch decrements score, 0 = wrong switch ignored
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
start  in  1  debounced start request, level; rising edge acts
sw  in  N_CH  raw slide switches, asynchronous to clk
led  out  N_CH  one-hot target indicator
timer_out  out  TIMER_W  remaining ticks in round
score_out  out  SCORE_W  current round score
best_out  out  SCORE_W  best score since reset
busy  out  1  high in LOAD/RUN
done  out  1  high in DONE

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; led, timer_out, score_out, best_out all 0; busy=done=0.
  - LFSR=LFSR_SEED; tick counter=0.
- Input conditioning:
  - sw passes through a 2-flop synchroniser plus a previous-value register.
  - sw_rise = synced & ~prev.
  - start is registered once; start_rise = start & ~start_q.
- Tick: counter runs 0..TICK_DIV-1 only in RUN and pulses tick for one cycle at TICK_DIV-1, then wraps to 0. Counter clears in LOAD.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state.
  - cand = LFSR mod N_CH.
  - new target = cand, or (cand+1) mod N_CH if cand equals the current target, so consecutive targets always differ.
- FSM:
  - IDLE: led=0. start_rise -> LOAD.
  - LOAD (1 cycle): timer=ROUND_TICKS, score=0, pick target -> RUN.
  - RUN:
    - led = one-hot(target).
    - Event priority within one cycle: score update first, then tick.
    - hit: sw_rise == one-hot(target) exactly. score+1, saturating at 2^SCORE_W-1; new target latched the next cycle.
    - miss: sw_rise non-zero and not exactly the target (includes target plus another bit). If PENALTY=1, score-1 saturating at 0; target unchanged.
    - tick: timer-1. If timer==1 on that tick, timer becomes 0 -> DONE.
    - start_rise is ignored.
  - DONE:
    - led=0; done=1; timer_out=0; score_out holds the final score.
    - On entry, best_out = max(best, final score), including a hit that lands on the final tick.
    - start_rise -> LOAD.
- Latency: sw edge to score_out change = 3 clk cycles (2 sync + 1 update).
- Timer and score are never driven outside 0..ROUND_TICKS and 0..2^SCORE_W-1 respectively.
- Reset mid-round aborts to IDLE. best_out is also cleared by reset.

Decomposition:
- Package rg_pkg:
  - state enum {IDLE, LOAD, RUN, DONE}
  - LFSR tap constant
  - onehot(idx, N) function
  - sat_inc / sat_dec helper functions
- One natural sub-module: rg_lfsr (free-running LFSR with seed parameter and synchronous active-low reset).
- Tick counter, synchroniser and FSM stay in reaction_game_core.

Test Plan (N_CH=4, TICK_DIV=4, ROUND_TICKS=3, SCORE_W=4):
- Reset held 5 cycles, then released with start low -> all outputs 0; state remains IDLE for 20 cycles.
- start pulse -> busy=1 after 1 cycle; timer_out=3; led one-hot; timer reaches 0 and done=1 exactly 12 RUN cycles after LOAD.
- Raise the target switch -> score_out=1 three cycles later; led moves to a different bit on the following cycle.
- PENALTY=1: raise a non-target switch with score=0 -> score stays 0. After 2 hits, a wrong switch -> score 1. Target + non-target together -> counts as a miss.
- Hit in the same cycle as the final tick -> score includes the hit; best_out updates. Next round scores lower -> best_out unchanged. 17 hits with SCORE_W=4 -> score saturates at 15.
- Reset asserted mid-RUN -> next cycle: IDLE, led=0, timer=0, score=0, best=0; start pressed during RUN -> no restart.
